// File: rtl/general_register_file.sv
// general_register_file
// Eight 32-bit i386 general registers (EAX..EDI) with two registered read
// ports and one write port. Register codes and operand sizes come from the
// general register decoder; byte codes 4..7 select AH/CH/DH/BH.
// Optional feature macro: GENERAL_REGISTER_BYPASS_EN. When defined, a read
// coinciding with a write to the same register returns the post-merge value.
// Otherwise it returns the pre-write value.
module general_register_file #(
    parameter logic [31:0] RESET_EDX = 32'h0000_0308
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd0_req,
    input  logic [2:0]  rd0_code,
    input  logic [1:0]  rd0_size,
    output logic        rd0_valid,
    output logic [31:0] rd0_data,
    input  logic        rd1_req,
    input  logic [2:0]  rd1_code,
    input  logic [1:0]  rd1_size,
    output logic        rd1_valid,
    output logic [31:0] rd1_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_code,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data
);

    // Operand size encoding; 2'b11 falls through to the dword case.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;

    // Physical register selected by a code: byte codes 4..7 alias regs 0..3.
    function automatic logic [2:0] reg_index(input logic [2:0] code,
                                             input logic [1:0] size);
        return (size == SZ_BYTE) ? {1'b0, code[1:0]} : code;
    endfunction

    // Replace only the addressed slice of old_val with the low bits of data.
    function automatic logic [31:0] merge_slice(input logic [31:0] old_val,
                                                input logic [2:0]  code,
                                                input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] result;
        case (size)
            SZ_BYTE: result = code[2] ? {old_val[31:16], data[7:0], old_val[7:0]}
                                      : {old_val[31:8], data[7:0]};
            SZ_WORD: result = {old_val[31:16], data[15:0]};
            default: result = data;
        endcase
        return result;
    endfunction

    // Extract the addressed slice right-aligned and zero-extended.
    function automatic logic [31:0] extract_slice(input logic [31:0] val,
                                                  input logic [2:0]  code,
                                                  input logic [1:0]  size);
        logic [31:0] result;
        case (size)
            SZ_BYTE: result = code[2] ? {24'h0, val[15:8]} : {24'h0, val[7:0]};
            SZ_WORD: result = {16'h0, val[15:0]};
            default: result = val;
        endcase
        return result;
    endfunction

    logic [31:0] regs [8];

    logic [2:0]  wr_idx;
    logic [31:0] wr_merged;
    logic [2:0]  rd0_idx;
    logic [2:0]  rd1_idx;
    logic [31:0] rd0_src;
    logic [31:0] rd1_src;

    // Address decode, write merge and read source selection.
    always_comb begin
        wr_idx    = reg_index(wr_code, wr_size);
        wr_merged = merge_slice(regs[wr_idx], wr_code, wr_size, wr_data);
        rd0_idx   = reg_index(rd0_code, rd0_size);
        rd1_idx   = reg_index(rd1_code, rd1_size);
`ifdef GENERAL_REGISTER_BYPASS_EN
        rd0_src   = (wr_en && (wr_idx == rd0_idx)) ? wr_merged : regs[rd0_idx];
        rd1_src   = (wr_en && (wr_idx == rd1_idx)) ? wr_merged : regs[rd1_idx];
`else
        rd0_src   = regs[rd0_idx];
        rd1_src   = regs[rd1_idx];
`endif
    end

    // Register array: reset values, then one merged slice write per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the array is reset on purpose because software reads the
            // architectural reset values (EDX holds the component ID), so it
            // cannot map to a plain RAM macro; the later EDX assignment wins.
            regs       <= '{default: 32'h0};
            regs[3'd2] <= RESET_EDX;
        end else if (wr_en) begin
            // NOTE: non-blocking so the read ports above still see the
            // pre-edge array value within the same cycle.
            regs[wr_idx] <= wr_merged;
        end
    end

    // Read port output registers; data holds when no request is made.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd0_valid <= 1'b0;
            rd0_data  <= 32'h0;
            rd1_valid <= 1'b0;
            rd1_data  <= 32'h0;
        end else begin
            rd0_valid <= rd0_req;
            rd1_valid <= rd1_req;
            if (rd0_req) rd0_data <= extract_slice(rd0_src, rd0_code, rd0_size);
            if (rd1_req) rd1_data <= extract_slice(rd1_src, rd1_code, rd1_size);
        end
    end

endmodule

// File: tb/tb_general_register_file.sv
// Self-checking bench for general_register_file: a table of per-cycle
// vectors with expected read results, plus hand-written reset sequences.
module tb_general_register_file;

    localparam logic [1:0] B  = 2'b00;
    localparam logic [1:0] W  = 2'b01;
    localparam logic [1:0] D  = 2'b10;
    localparam logic [1:0] D3 = 2'b11;

`ifdef GENERAL_REGISTER_BYPASS_EN
    localparam logic [31:0] COLL_EBX = 32'h0000_0005;
    localparam logic [31:0] COLL_AX  = 32'h0000_7755;
`else
    localparam logic [31:0] COLL_EBX = 32'h0000_0000;
    localparam logic [31:0] COLL_AX  = 32'h0000_AA55;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        rd0_req, rd1_req, wr_en;
    logic [2:0]  rd0_code, rd1_code, wr_code;
    logic [1:0]  rd0_size, rd1_size, wr_size;
    logic [31:0] wr_data;
    logic        rd0_valid, rd1_valid;
    logic [31:0] rd0_data, rd1_data;

    int checks = 0;
    int errors = 0;

    general_register_file dut (
        .clock    (clock),
        .reset    (reset),
        .rd0_req  (rd0_req),
        .rd0_code (rd0_code),
        .rd0_size (rd0_size),
        .rd0_valid(rd0_valid),
        .rd0_data (rd0_data),
        .rd1_req  (rd1_req),
        .rd1_code (rd1_code),
        .rd1_size (rd1_size),
        .rd1_valid(rd1_valid),
        .rd1_data (rd1_data),
        .wr_en    (wr_en),
        .wr_code  (wr_code),
        .wr_size  (wr_size),
        .wr_data  (wr_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        wr_en;
        logic [2:0]  wr_code;
        logic [1:0]  wr_size;
        logic [31:0] wr_data;
        logic        rd0_req;
        logic [2:0]  rd0_code;
        logic [1:0]  rd0_size;
        logic        rd1_req;
        logic [2:0]  rd1_code;
        logic [1:0]  rd1_size;
        logic [31:0] exp0;   // rd0_data after the edge (held value if no req)
        logic [31:0] exp1;
    } vec_t;

    function automatic vec_t mk(input string n,
                                input logic we, input logic [2:0] wc,
                                input logic [1:0] ws, input logic [31:0] wd,
                                input logic r0, input logic [2:0] c0,
                                input logic [1:0] s0,
                                input logic r1, input logic [2:0] c1,
                                input logic [1:0] s1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.name = n;
        v.wr_en = we;   v.wr_code = wc;  v.wr_size = ws;  v.wr_data = wd;
        v.rd0_req = r0; v.rd0_code = c0; v.rd0_size = s0;
        v.rd1_req = r1; v.rd1_code = c1; v.rd1_size = s1;
        v.exp0 = e0;    v.exp1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en = v.wr_en;     wr_code = v.wr_code;   wr_size = v.wr_size;
        wr_data = v.wr_data;
        rd0_req = v.rd0_req; rd0_code = v.rd0_code; rd0_size = v.rd0_size;
        rd1_req = v.rd1_req; rd1_code = v.rd1_code; rd1_size = v.rd1_size;
    endtask

    // Apply one vector for one edge, then check both ports 1 ns later.
    task automatic run_vec(input vec_t v);
        drive(v);
        @(posedge clock);
        #1;
        check({v.name, " rd0_valid"}, {31'h0, rd0_valid}, {31'h0, v.rd0_req});
        check({v.name, " rd1_valid"}, {31'h0, rd1_valid}, {31'h0, v.rd1_req});
        check({v.name, " rd0_data"}, rd0_data, v.exp0);
        check({v.name, " rd1_data"}, rd1_data, v.exp1);
    endtask

    vec_t vecs [22];

    initial begin
        //                 name         we wc    ws wdata          r0 c0    s0  r1 c1    s1  exp0           exp1
        vecs[0]  = mk("rst c0/c7",    0, 3'd0, D, 32'h0,         1, 3'd0, D,  1, 3'd7, D,  32'h0,         32'h0);
        vecs[1]  = mk("rst c1/c6",    0, 3'd0, D, 32'h0,         1, 3'd1, D,  1, 3'd6, D,  32'h0,         32'h0);
        vecs[2]  = mk("rst c2/c5",    0, 3'd0, D, 32'h0,         1, 3'd2, D,  1, 3'd5, D,  32'h0000_0308, 32'h0);
        vecs[3]  = mk("rst c3/c4",    0, 3'd0, D, 32'h0,         1, 3'd3, D,  1, 3'd4, D,  32'h0,         32'h0);
        vecs[4]  = mk("wr EAX",       1, 3'd0, D, 32'h1122_3344, 0, 3'd0, D,  0, 3'd0, D,  32'h0,         32'h0);
        vecs[5]  = mk("wr AH",        1, 3'd4, B, 32'hFFFF_FFAA, 0, 3'd0, D,  0, 3'd0, D,  32'h0,         32'h0);
        vecs[6]  = mk("wr AL",        1, 3'd0, B, 32'hFFFF_FF55, 0, 3'd0, D,  0, 3'd0, D,  32'h0,         32'h0);
        vecs[7]  = mk("rd EAX/AX",    0, 3'd0, D, 32'h0,         1, 3'd0, D,  1, 3'd0, W,  32'h1122_AA55, 32'h0000_AA55);
        vecs[8]  = mk("rd AH/AL",     0, 3'd0, D, 32'h0,         1, 3'd4, B,  1, 3'd0, B,  32'h0000_00AA, 32'h0000_0055);
        vecs[9]  = mk("wr ESI",       1, 3'd6, D, 32'hDEAD_BEEF, 0, 3'd0, D,  0, 3'd0, D,  32'h0000_00AA, 32'h0000_0055);
        vecs[10] = mk("wr SI",        1, 3'd6, W, 32'hFFFF_1234, 0, 3'd0, D,  0, 3'd0, D,  32'h0000_00AA, 32'h0000_0055);
        vecs[11] = mk("rd ESI/DH",    0, 3'd0, D, 32'h0,         1, 3'd6, D,  1, 3'd6, B,  32'hDEAD_1234, 32'h0000_0003);
        vecs[12] = mk("wr ECX",       1, 3'd1, D, 32'h0000_0F0E, 0, 3'd0, D,  0, 3'd0, D,  32'hDEAD_1234, 32'h0000_0003);
        vecs[13] = mk("rd CL/ECX",    0, 3'd0, D, 32'h0,         1, 3'd1, B,  1, 3'd1, D,  32'h0000_000E, 32'h0000_0F0E);
        vecs[14] = mk("coll EBX",     1, 3'd3, D, 32'h0000_0005, 1, 3'd3, D,  1, 3'd3, B,  COLL_EBX,      COLL_EBX);
        vecs[15] = mk("after coll",   0, 3'd0, D, 32'h0,         1, 3'd3, D,  0, 3'd0, D,  32'h0000_0005, COLL_EBX);
        vecs[16] = mk("coll AH/AX",   1, 3'd4, B, 32'h0000_0077, 1, 3'd0, W,  1, 3'd7, B,  COLL_AX,       32'h0);
        vecs[17] = mk("rd AX/CH",     0, 3'd0, D, 32'h0,         1, 3'd0, W,  1, 3'd5, B,  32'h0000_7755, 32'h0000_000F);
        vecs[18] = mk("rd size11",    0, 3'd0, D, 32'h0,         1, 3'd6, D3, 0, 3'd0, D,  32'hDEAD_1234, 32'h0000_000F);
        vecs[19] = mk("wr EDI sz11",  1, 3'd7, D3,32'hCAFE_F00D, 0, 3'd0, D,  0, 3'd0, D,  32'hDEAD_1234, 32'h0000_000F);
        vecs[20] = mk("rd EDI/BL",    0, 3'd0, D, 32'h0,         1, 3'd7, D,  1, 3'd3, B,  32'hCAFE_F00D, 32'h0000_0005);
        vecs[21] = mk("idle hold",    0, 3'd0, D, 32'h0,         0, 3'd0, D,  0, 3'd0, D,  32'hCAFE_F00D, 32'h0000_0005);

        // Reset with requests and a write pending: all must be ignored.
        reset = 1'b1;
        drive(mk("rst", 1, 3'd0, D, 32'hFFFF_FFFF, 1, 3'd0, D, 1, 3'd1, D, 32'h0, 32'h0));
        repeat (2) @(posedge clock);
        #1;
        check("reset rd0_valid", {31'h0, rd0_valid}, 32'h0);
        check("reset rd1_valid", {31'h0, rd1_valid}, 32'h0);
        check("reset rd0_data", rd0_data, 32'h0);
        check("reset rd1_data", rd1_data, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) run_vec(vecs[i]);

        // Continuous reads of EAX with a one-cycle reset pulse in the middle.
        run_vec(mk("pre-rst EAX", 0, 3'd0, D, 32'h0, 1, 3'd0, D, 0, 3'd0, D,
                   32'h1122_7755, 32'h0000_0005));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid-rst rd0_valid", {31'h0, rd0_valid}, 32'h0);
        check("mid-rst rd0_data", rd0_data, 32'h0);
        reset = 1'b0;
        run_vec(mk("post-rst EAX", 0, 3'd0, D, 32'h0, 1, 3'd0, D, 1, 3'd2, D,
                   32'h0, 32'h0000_0308));
        run_vec(mk("post-rst ESI/EDI", 0, 3'd0, D, 32'h0, 1, 3'd6, D, 1, 3'd7, D,
                   32'h0, 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/general_register_file.md
# general_register_file

Eight 32-bit i386 general registers (EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI) with two registered read ports and one write port. It sits directly downstream of `decode_general_register` and consumes its output: the 3-bit register sequence code plus the operand size derived from `w` and the operand-size attribute. It maps that code onto 8/16/32-bit register slices, including AH/CH/DH/BH, and performs the byte-lane merge on writes.

## Interface
Parameters:
- `RESET_EDX`, default `32'h0000_0308`: EDX value after reset (component/revision ID).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd0_req`  in  1  read request, port 0.
- `rd0_code`  in  3  register sequence code, port 0.
- `rd0_size`  in  2  size: 00 byte, 01 word, 10 dword, 11 treated as dword.
- `rd0_valid`  out  1  port 0 data valid, one cycle after `rd0_req`.
- `rd0_data`  out  32  port 0 read data, zero-extended.
- `rd1_req`, `rd1_code`, `rd1_size`, `rd1_valid`, `rd1_data`: same as port 0, for port 1.
- `wr_en`  in  1  write strobe.
- `wr_code`  in  3  register sequence code.
- `wr_size`  in  2  encoding as for reads.
- `wr_data`  in  32  write data; only the low slice-width bits are used.

## Operation
- Slice mapping for code c:
  - byte, c<4: bits [7:0] of reg c (AL, CL, DL, BL).
  - byte, c>=4: bits [15:8] of reg c-4 (AH, CH, DH, BH).
  - word: bits [15:0] of reg c.
  - dword: bits [31:0] of reg c.
- Write: on a rising edge with `wr_en`=1, only the mapped slice of the target register is replaced by `wr_data[width-1:0]`. All other bits are unchanged.
- Read: on a rising edge with `rdN_req`=1, the mapped slice is captured right-aligned into `rdN_data` and the upper bits are zeroed. `rdN_valid` is set to 1.
- With `rdN_req`=0, `rdN_valid` goes to 0 and `rdN_data` holds its last value.
- Both read ports are independent. Both may address the same register in the same cycle.
- Reset:
  - All registers are 0 except EDX, which takes `RESET_EDX`.
  - `rd0_valid`, `rd1_valid` = 0.
  - `rd0_data`, `rd1_data` = 0.
  - Requests and writes in the reset cycle are ignored.
- There is no state machine beyond the register array and the output registers. There is no backpressure: every request is served.

## Timing
- Read latency is 1 cycle: a request at edge N gives valid data after edge N, sampled at edge N+1.
- A write is visible to a read issued in any later cycle.
- Same-cycle read and write to the same 32-bit register is governed by the configuration below. It applies regardless of whether the slices overlap (e.g. write AH while reading AX).
- Back-to-back requests on every cycle are allowed. Throughput is 1 read per port per cycle plus 1 write per cycle.
- Reset asserted mid-stream: in the next cycle `rdN_valid` is 0, even if a request was pending. Register contents revert to their reset values.

## Configuration
- `GENERAL_REGISTER_BYPASS_EN` defined: a read that coincides with a write to the same register returns the post-merge value, as if the write happened first.
- Not defined: that read returns the pre-write value. The write still commits at the same edge.

## Test plan
- Reset check: after reset, dword reads of codes 0..7 return 0 except code 2 (EDX) = `32'h0000_0308`. Both valid outputs are 0 during reset.
- Byte-lane merge:
  - Write dword EAX = `32'h1122_3344`.
  - Write byte code 4 (AH) = `8'hAA`.
  - Write byte code 0 (AL) = `8'h55`.
  - Dword read of EAX returns `32'h1122_AA55`.
  - Word read of AX returns `32'h0000_AA55`.
  - Byte read of code 4 returns `32'h0000_00AA`.
- Word write preserves the upper half: ESI = `32'hDEAD_BEEF`, then word write code 6 = `16'h1234` → dword read of ESI = `32'hDEAD_1234`.
- Dual port: in one cycle, port 0 reads CL and port 1 reads ECX, with ECX = `32'h0000_0F0E`. Next cycle: both valid, `rd0_data` = `32'h0E`, `rd1_data` = `32'h0F0E`.
- Collision: EBX = 0; write dword EBX = `32'h5` and read EBX in the same cycle. Expect 5 with `GENERAL_REGISTER_BYPASS_EN`, 0 without. A read one cycle later returns 5 in both builds.
- Reset mid-stream: continuous `rd0_req` with `reset` pulsed for 1 cycle → `rd0_valid` is 0 for the cycle after reset, then returns to 1 with post-reset values.
